// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: steers store lanes, extends loads and
// stalls the pipeline across a req/ready data-memory handshake.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic [1:0]  MemWriteM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic        ErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  lsize_q, lsize_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        terr_q, terr_d;

    logic [1:0]  a_lo;
    logic        is_st;
    logic        is_ld;
    logic        pend;
    logic        misal;
    logic        bad_code;
    logic        illegal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] rsh;
    logic [15:0] hw;
    logic [31:0] ld_ext;

    assign a_lo    = ALUResultM[1:0];
    assign is_st   = |MemWriteM;
    assign is_ld   = MemReadM & ~is_st;
    assign pend    = is_st | is_ld;
    assign illegal = pend & (misal | bad_code);

    // A store always wins over a load presented in the same cycle.
    always_comb begin
        misal    = 1'b0;
        bad_code = 1'b0;
        be_n     = 4'b1111;
        wd_n     = '0;
        unique case (1'b1)
            MemWriteM == 2'b01: begin
                misal = |a_lo;
                wd_n  = WriteDataM;
            end
            MemWriteM == 2'b10: begin
                misal = a_lo[0];
                be_n  = a_lo[1] ? 4'b1100 : 4'b0011;
                wd_n  = {2{WriteDataM[15:0]}};
            end
            MemWriteM == 2'b11: begin
                be_n = 4'b0001 << a_lo;
                wd_n = {4{WriteDataM[7:0]}};
            end
            default: begin
                unique case (LoadSizeM)
                    3'b000:         misal    = |a_lo;
                    3'b011, 3'b100: misal    = a_lo[0];
                    3'b001, 3'b010: misal    = 1'b0;
                    default:        bad_code = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        rsh = mem_rdata >> {lo_q, 3'b000};
        hw  = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (lsize_q)
            3'b001:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
            3'b010:  ld_ext = {24'd0, rsh[7:0]};
            3'b011:  ld_ext = {{16{hw[15]}}, hw};
            3'b100:  ld_ext = {16'd0, hw};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        lsize_d = lsize_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        terr_d  = 1'b0;
        StallM  = 1'b0;
        ErrM    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Held in reset, nothing is stalled or flagged.
                if (pend && reset_n) begin
                    if (illegal) begin
                        ErrM = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_st;
                        addr_d  = {ALUResultM[31:2], 2'b00};
                        be_d    = be_n;
                        wdata_d = wd_n;
                        lsize_d = LoadSizeM;
                        lo_d    = a_lo;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                cnt_d  = cnt_q + 8'd1;
                if (mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = '0;
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ErrM    = terr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            lsize_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lsize_q <= lsize_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign ReadDataM = rdata_q;
    assign DoneM     = done_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus randomized accesses
// checked against an arithmetic model of lane steering and extension.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemReadM;
    logic [1:0]  MemWriteM;
    logic [2:0]  LoadSizeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, DoneM, ErrM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic [31:0] to_rd, to_addr, to_wdata;
    logic        to_stall, to_done, to_err, to_req, to_we;
    logic [3:0]  to_be;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rd = 0;

    int          r_stalls, r_reqn, r_errs, r_dcyc;
    bit          r_done, r_derr, r_stable, r_fin;
    logic [31:0] r_rd, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .LoadSizeM(LoadSizeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallM(StallM), .DoneM(DoneM), .ErrM(ErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_stage_lsu #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .LoadSizeM(LoadSizeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .ReadDataM(to_rd),
        .StallM(to_stall), .DoneM(to_done), .ErrM(to_err),
        .mem_req(to_req), .mem_we(to_we), .mem_addr(to_addr),
        .mem_be(to_be), .mem_wdata(to_wdata),
        .mem_ready(1'b0), .mem_rdata(mem_rdata)
    );

    function automatic bit m_illegal(logic mr, logic [1:0] mw,
                                     logic [2:0] ls, logic [31:0] a);
        int unsigned o = a % 4;
        if (mw == 1) return o != 0;
        if (mw == 2) return (o % 2) != 0;
        if (mw == 3) return 1'b0;
        if (!mr) return 1'b0;
        if (ls > 4) return 1'b1;
        if (ls == 0) return o != 0;
        if (ls == 3 || ls == 4) return (o % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] mw, logic [31:0] a);
        int unsigned o = a % 4;
        if (mw == 2) return (o >= 2) ? 4'd12 : 4'd3;
        if (mw == 3) return 4'(1 << o);
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wd(logic [1:0] mw, logic [31:0] wd);
        if (mw == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        if (mw == 3) return (wd & 32'hFF) * 32'h0101_0101;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] ls, logic [31:0] a,
                                           logic [31:0] w);
        int unsigned o, b, h;
        o = a % 4;
        b = (w >> (8 * o)) & 32'hFF;
        h = (w >> (16 * (o / 2))) & 32'hFFFF;
        case (ls)
            3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    task automatic clear_in();
        MemReadM   = 1'b0;
        MemWriteM  = 2'b00;
        LoadSizeM  = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        mem_ready  = 1'b0;
    endtask

    // Presents one instruction and plays the memory side until MEM releases.
    task automatic run_acc(input logic mr, input logic [1:0] mw,
                           input logic [2:0] ls, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rw,
                           input int wait_n, input bit noise);
        MemReadM = mr; MemWriteM = mw; LoadSizeM = ls;
        ALUResultM = a; WriteDataM = wd; mem_rdata = rw;
        mem_ready = 1'b0;
        r_stalls = 0; r_reqn = 0; r_errs = 0; r_dcyc = 0;
        r_done = 0; r_derr = 0; r_stable = 1; r_fin = 0; r_rd = 'x;
        for (int k = 0; k < 40 && !r_fin; k++) begin
            @(negedge clk);
            if (StallM) r_stalls++;
            if (ErrM) r_errs++;
            if (mem_req) begin
                if (r_reqn == 0) begin
                    r_we = mem_we; r_addr = mem_addr;
                    r_be = mem_be; r_wdata = mem_wdata;
                end else if ({mem_we, mem_addr, mem_be, mem_wdata} !==
                             {r_we, r_addr, r_be, r_wdata}) begin
                    r_stable = 0;
                end
                r_reqn++;
            end
            if (DoneM) begin
                r_done = 1; r_derr = ErrM; r_rd = ReadDataM; r_dcyc = k + 1;
            end
            if (!StallM) r_fin = 1;
            if (r_reqn == 0) mem_ready = noise ? 1'($urandom % 2) : 1'b0;
            else mem_ready = mem_req && (r_reqn == wait_n + 1);
            @(posedge clk);
            #1;
        end
        clear_in();
        if (!r_fin) begin
            total++; bad++;
            $display("FAIL hang: access at %h never released MEM", a);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_in();
        mem_rdata = '0;
        #2;
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM,
             DoneM, ErrM, StallM} !== '0) begin
            bad++;
            $display("FAIL reset_hold: req=%b be=%h addr=%h rd=%h st=%b, want 0",
                     mem_req, mem_be, mem_addr, ReadDataM, StallM);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if ({mem_req, DoneM, ErrM, StallM, ReadDataM} !== '0) begin
            bad++;
            $display("FAIL reset_idle: req=%b done=%b err=%b st=%b rd=%h, want 0",
                     mem_req, DoneM, ErrM, StallM, ReadDataM);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lb();
        run_acc(1, 0, 3'b001, 32'h1003, 0, 32'h80FF_1234, 0, 0);
        exp_rd = 32'hFFFF_FF80;
        total++;
        if (r_addr !== 32'h1000 || r_be !== 4'hF || r_we !== 1'b0) begin
            bad++;
            $display("FAIL lb_bus: addr=%h be=%b we=%b, want 1000 1111 0",
                     r_addr, r_be, r_we);
        end
        total++;
        if (r_rd !== exp_rd || r_dcyc !== 3 || r_stalls !== 2) begin
            bad++;
            $display("FAIL lb_data: rd=%h cyc=%0d stalls=%0d, want %h 3 2",
                     r_rd, r_dcyc, r_stalls, exp_rd);
        end
    endtask

    task automatic test_sh();
        run_acc(0, 2'b10, 0, 32'h2002, 32'hDEAD_BEEF, 0, 4, 0);
        total++;
        if (r_we !== 1'b1 || r_be !== 4'b1100 || r_wdata !== 32'hBEEF_BEEF ||
            r_addr !== 32'h2000 || !r_stable) begin
            bad++;
            $display("FAIL sh_bus: we=%b be=%b wd=%h addr=%h stable=%b",
                     r_we, r_be, r_wdata, r_addr, r_stable);
        end
        total++;
        if (r_stalls !== 6 || r_reqn !== 5 || !r_done || r_derr ||
            r_rd !== exp_rd) begin
            bad++;
            $display("FAIL sh_timing: stalls=%0d/6 req=%0d/5 done=%b rd=%h/%h",
                     r_stalls, r_reqn, r_done, r_rd, exp_rd);
        end
    endtask

    task automatic test_misaligned();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) run_acc(1, 0, 3'b000, 32'h3001, 0, 0, 0, 0);
            else run_acc(0, 2'b01, 0, 32'h3002, 32'h1234_5678, 0, 0, 0);
            total++;
            if (r_stalls !== 0 || r_errs !== 1 || r_reqn !== 0 || r_done) begin
                bad++;
                $display("FAIL misal%0d: stalls=%0d err=%0d req=%0d done=%b",
                         i, r_stalls, r_errs, r_reqn, r_done);
            end
            @(negedge clk);
            total++;
            if (ErrM !== 1'b0 || StallM !== 1'b0 || mem_req !== 1'b0 ||
                ReadDataM !== exp_rd) begin
                bad++;
                $display("FAIL misal%0d_after: err=%b st=%b req=%b rd=%h/%h",
                         i, ErrM, StallM, mem_req, ReadDataM, exp_rd);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        run_acc(1, 2'b11, 3'b000, 32'h5, 32'h0000_00A7, 32'hFFFF_FFFF, 1, 0);
        total++;
        if (r_we !== 1'b1 || r_be !== 4'b0010 || r_wdata !== 32'hA7A7_A7A7 ||
            r_reqn !== 2 || r_rd !== exp_rd) begin
            bad++;
            $display("FAIL prio_sb: we=%b be=%b wd=%h req=%0d rd=%h",
                     r_we, r_be, r_wdata, r_reqn, r_rd);
        end
        run_acc(1, 0, 3'b000, 32'h104, 0, 32'h1122_3344, 0, 0);
        exp_rd = 32'h1122_3344;
        total++;
        if (r_we !== 1'b0 || r_addr !== 32'h104 || r_reqn !== 1 ||
            r_stalls !== 2 || r_rd !== exp_rd) begin
            bad++;
            $display("FAIL b2b_lw: we=%b addr=%h req=%0d st=%0d rd=%h/%h",
                     r_we, r_addr, r_reqn, r_stalls, r_rd, exp_rd);
        end
    endtask

    task automatic test_random();
        logic        mr;
        logic [1:0]  mw;
        logic [2:0]  ls;
        logic [31:0] a, wd, rw, e_rd;
        int          wt, e_st, e_rq, e_er;
        bit          ill, pend;
        for (int n = 0; n < 60; n++) begin
            mr = ($urandom % 4) != 0;
            mw = 2'($urandom % 4);
            if ($urandom % 2) mw = 0;
            ls = 3'($urandom % 8);
            a = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            wd = $urandom;
            rw = $urandom;
            wt = int'($urandom_range(0, 5));
            run_acc(mr, mw, ls, a, wd, rw, wt, 1);
            pend = mr || (mw != 0);
            ill = pend && m_illegal(mr, mw, ls, a);
            e_st = (pend && !ill) ? wt + 2 : 0;
            e_rq = (pend && !ill) ? wt + 1 : 0;
            e_er = ill ? 1 : 0;
            if (pend && !ill && mw == 0) exp_rd = m_load(ls, a, rw);
            total++;
            if (r_stalls !== e_st || r_reqn !== e_rq || r_errs !== e_er) begin
                bad++;
                $display("FAIL rnd%0d_timing: st=%0d/%0d req=%0d/%0d err=%0d/%0d",
                         n, r_stalls, e_st, r_reqn, e_rq, r_errs, e_er);
            end
            if (pend && !ill) begin
                total++;
                if (r_addr !== (a & 32'hFFFF_FFFC) || r_be !== m_be(mw, a) ||
                    r_we !== (mw != 0) || !r_stable ||
                    (mw != 0 && r_wdata !== m_wd(mw, wd))) begin
                    bad++;
                    $display("FAIL rnd%0d_bus: addr=%h be=%b we=%b wd=%h stable=%b",
                             n, r_addr, r_be, r_we, r_wdata, r_stable);
                end
                e_rd = exp_rd;
                total++;
                if (!r_done || r_derr || r_rd !== e_rd) begin
                    bad++;
                    $display("FAIL rnd%0d_data: done=%b err=%b rd=%h want %h",
                             n, r_done, r_derr, r_rd, e_rd);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int to_st, to_rq, m_st;
        bit to_fin, m_fin, to_de, m_de;
        logic [31:0] to_v, m_v;
        run_acc(1, 0, 3'b000, 32'h200, 0, 32'h5A5A_0001, 0, 0);
        exp_rd = 32'h5A5A_0001;
        repeat (10) @(posedge clk);
        #1;
        MemReadM = 1'b1; LoadSizeM = 3'b010; ALUResultM = 32'h10;
        mem_ready = 1'b0;
        to_st = 0; to_rq = 0; m_st = 0;
        to_fin = 0; m_fin = 0; to_de = 0; m_de = 0;
        to_v = 'x; m_v = 'x;
        for (int k = 0; k < 40 && !m_fin; k++) begin
            @(negedge clk);
            if (!to_fin) begin
                if (to_stall) to_st++;
                if (to_req) to_rq++;
                if (!to_stall) begin
                    to_fin = 1; to_de = to_done & to_err; to_v = to_rd;
                end
            end
            if (StallM) m_st++;
            else begin
                m_fin = 1; m_de = DoneM & ErrM; m_v = ReadDataM;
            end
            @(posedge clk);
            #1;
            if (to_fin) clear_in();
        end
        clear_in();
        exp_rd = 0;
        total++;
        if (to_rq !== 4 || to_st !== 5 || !to_de || to_v !== 32'h0) begin
            bad++;
            $display("FAIL timeout4: req=%0d/4 st=%0d/5 err=%b rd=%h",
                     to_rq, to_st, to_de, to_v);
        end
        total++;
        if (!m_fin || m_st !== 17 || !m_de || m_v !== 32'h0) begin
            bad++;
            $display("FAIL timeout16: fin=%b st=%0d/17 err=%b rd=%h want 0",
                     m_fin, m_st, m_de, m_v);
        end
        @(negedge clk);
        total++;
        if (StallM !== 1'b0 || ErrM !== 1'b0 || to_stall !== 1'b0 ||
            to_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: st=%b err=%b to_st=%b to_err=%b",
                     StallM, ErrM, to_stall, to_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        run_acc(1, 0, 3'b000, 32'h300, 0, 32'hCAFE_F00D, 0, 0);
        exp_rd = 32'hCAFE_F00D;
        total++;
        if (r_rd !== exp_rd) begin
            bad++;
            $display("FAIL pre_reset_lw: rd=%h want %h", r_rd, exp_rd);
        end
        MemReadM = 1'b1; LoadSizeM = 3'b000; ALUResultM = 32'h40;
        seen = 0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            seen = mem_req;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_mid_busy: mem_req never rose");
        end
        #2;
        reset_n = 1'b0;
        clear_in();
        #1;
        exp_rd = 0;
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM,
             DoneM, ErrM, StallM} !== '0) begin
            bad++;
            $display("FAIL reset_mid: req=%b st=%b be=%h addr=%h rd=%h, want 0",
                     mem_req, StallM, mem_be, mem_addr, ReadDataM);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || DoneM !== 1'b0) begin
            bad++;
            $display("FAIL reset_noretry: req=%b st=%b done=%b, want 0",
                     mem_req, StallM, DoneM);
        end
        @(posedge clk);
        #1;
        run_acc(1, 0, 3'b100, 32'h22, 0, 32'h8001_0000, 0, 0);
        exp_rd = 32'h0000_8001;
        total++;
        if (r_rd !== exp_rd || r_stalls !== 2 || r_addr !== 32'h20) begin
            bad++;
            $display("FAIL lhu_after_reset: rd=%h/%h st=%0d addr=%h",
                     r_rd, exp_rd, r_stalls, r_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
